// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command/response controller.
//   rx_state_t          : RX assembly FSM encoding
//   tx_state_t          : TX byte sequencer encoding
//   OPND_FLAG_FROM_MSB  : distance of the "operand follows" flag from the byte MSB
//   opnd_flag_pos()     : absolute bit index of that flag for a given byte width
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_OPND = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  localparam int OPND_FLAG_FROM_MSB = 0;

  function automatic int opnd_flag_pos(input int n_bits);
    return n_bits - 1 - OPND_FLAG_FROM_MSB;
  endfunction

endpackage

// File: rtl/uart_ctrl_tx_seq.sv
// Response serializer: takes one response word and hands it to the UART
// transmitter one byte at a time, least-significant byte first.
//   i_clk, i_reset    : clock, async active-low reset
//   i_resp_valid/data : response word offer
//   o_resp_ready      : high only while idle
//   o_tx_start        : one-cycle pulse per byte
//   o_tx_data         : current byte, held until the next byte is launched
//   i_tx_done         : transmitter finished the current byte
//
// state    | meaning
// TX_IDLE  | waiting for a response word
// TX_START | o_tx_start is high for this single cycle
// TX_WAIT  | byte on the wire, waiting for i_tx_done
module uart_ctrl_tx_seq
  import uart_ctrl_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_resp_valid,
  input  logic [N_BITS*WORD_BYTES-1:0] i_resp_data,
  output logic                         o_resp_ready,
  output logic                         o_tx_start,
  output logic [N_BITS-1:0]            o_tx_data,
  input  logic                         i_tx_done
);

  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

  tx_state_t                   tx_state;
  logic [N_BITS*WORD_BYTES-1:0] word;
  logic [CNT_W-1:0]            idx;

  // The word is kept as a shift register: the low byte is always the next one
  // to send, so no byte-select mux is needed.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_state     <= TX_IDLE;
      word         <= '0;
      idx          <= '0;
      o_resp_ready <= 1'b1;
      o_tx_start   <= 1'b0;
      o_tx_data    <= '0;
    end else begin
      o_tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (i_resp_valid) begin
            o_tx_data    <= i_resp_data[N_BITS-1:0];
            word         <= i_resp_data >> N_BITS;
            idx          <= '0;
            o_tx_start   <= 1'b1;
            o_resp_ready <= 1'b0;
            tx_state     <= TX_START;
          end
        end
        TX_START: tx_state <= TX_WAIT;
        TX_WAIT: begin
          if (i_tx_done) begin
            if (idx == LAST_IDX) begin
              o_resp_ready <= 1'b1;
              tx_state     <= TX_IDLE;
            end else begin
              o_tx_data  <= word[N_BITS-1:0];
              word       <= word >> N_BITS;
              idx        <= idx + 1'b1;
              o_tx_start <= 1'b1;
              tx_state   <= TX_START;
            end
          end
        end
        default: begin
          o_resp_ready <= 1'b1;
          tx_state     <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART command/response controller.
// Receives a command byte (plus WORD_BYTES operand bytes when the command MSB
// is set), presents it on a valid/ready port, and serializes response words
// back out through the UART transmitter.
//   i_clk, i_reset         : clock, async active-low reset
//   i_rx_done/i_rx_data    : received byte strobe and data
//   o_tx_start/o_tx_data   : byte transmit request and data
//   i_tx_done              : byte transmit finished
//   o_cmd_valid/o_cmd/o_operand, i_cmd_ready : command handshake
//   i_resp_valid/i_resp_data, o_resp_ready    : response handshake
//   o_overrun              : sticky, a byte arrived while a command was pending
//   o_error                : one-cycle pulse on operand timeout abort
// Build option: define UART_CTRL_TIMEOUT_EN to abort a stalled operand after
// TIMEOUT_CYCLES idle cycles; otherwise operand reception waits forever.
//
// state   | meaning
// RX_IDLE | waiting for a command byte
// RX_OPND | collecting operand bytes, LSB first
// RX_HOLD | command presented, waiting for i_cmd_ready
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_rx_done,
  input  logic [N_BITS-1:0]            i_rx_data,
  output logic                         o_tx_start,
  output logic [N_BITS-1:0]            o_tx_data,
  input  logic                         i_tx_done,
  output logic                         o_cmd_valid,
  output logic [N_BITS-1:0]            o_cmd,
  output logic [N_BITS*WORD_BYTES-1:0] o_operand,
  input  logic                         i_cmd_ready,
  input  logic                         i_resp_valid,
  input  logic [N_BITS*WORD_BYTES-1:0] i_resp_data,
  output logic                         o_resp_ready,
  output logic                         o_overrun,
  output logic                         o_error
);

  localparam int CNT_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int FLAG_BIT = opnd_flag_pos(N_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

  rx_state_t        rx_state;
  logic [CNT_W-1:0] byte_cnt;

`ifdef UART_CTRL_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  // Down-counter reloaded on entry to RX_OPND and on every operand byte;
  // hitting zero with no byte arriving means TIMEOUT_CYCLES silent cycles.
  logic [TMR_W-1:0] tmr;
`else
  // TIMEOUT_CYCLES only matters when the timeout is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_state    <= RX_IDLE;
      byte_cnt    <= '0;
      o_cmd       <= '0;
      o_operand   <= '0;
      o_cmd_valid <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
      tmr         <= '0;
      o_error     <= 1'b0;
`endif
    end else begin
`ifdef UART_CTRL_TIMEOUT_EN
      o_error <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (i_rx_done) begin
            o_cmd     <= i_rx_data;
            o_operand <= '0;
            byte_cnt  <= '0;
            if (i_rx_data[FLAG_BIT]) begin
              rx_state <= RX_OPND;
`ifdef UART_CTRL_TIMEOUT_EN
              tmr      <= TMR_LOAD;
`endif
            end else begin
              o_cmd_valid <= 1'b1;
              rx_state    <= RX_HOLD;
            end
          end
        end
        RX_OPND: begin
          if (i_rx_done) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
              if (byte_cnt == CNT_W'(k)) o_operand[k*N_BITS +: N_BITS] <= i_rx_data;
            end
            if (byte_cnt == LAST_CNT) begin
              o_cmd_valid <= 1'b1;
              rx_state    <= RX_HOLD;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
`ifdef UART_CTRL_TIMEOUT_EN
            tmr <= TMR_LOAD;
`endif
          end
`ifdef UART_CTRL_TIMEOUT_EN
          else if (tmr == '0) begin
            o_operand <= '0;
            o_error   <= 1'b1;
            rx_state  <= RX_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        RX_HOLD: begin
          // Command must stay stable until consumed, so late bytes are dropped.
          if (i_rx_done) o_overrun <= 1'b1;
          if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            rx_state    <= RX_IDLE;
          end
        end
        default: begin
          o_cmd_valid <= 1'b0;
          rx_state    <= RX_IDLE;
        end
      endcase
    end
  end

  uart_ctrl_tx_seq #(
    .N_BITS     (N_BITS),
    .WORD_BYTES (WORD_BYTES)
  ) u_tx_seq (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_resp_valid (i_resp_valid),
    .i_resp_data  (i_resp_data),
    .o_resp_ready (o_resp_ready),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .i_tx_done    (i_tx_done)
  );

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter N_BITS, default 8, UART byte width.
REQ-002 SHALL have parameter WORD_BYTES, default 4, operand/response length in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500000, operand inter-byte timeout in i_clk cycles.
REQ-004 SHALL have port i_clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_rx_done  in  1  one-cycle pulse, received byte valid.
REQ-007 SHALL have port i_rx_data  in  N_BITS  received byte.
REQ-008 SHALL have port o_tx_start  out  1  one-cycle pulse, start byte transmission.
REQ-009 SHALL have port o_tx_data  out  N_BITS  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-010 SHALL have port i_tx_done  in  1  one-cycle pulse, byte transmission finished.
REQ-011 SHALL have port o_cmd_valid  out  1  command available.
REQ-012 SHALL have port o_cmd  out  N_BITS  command byte.
REQ-013 SHALL have port o_operand  out  N_BITS*WORD_BYTES  assembled operand.
REQ-014 SHALL have port i_cmd_ready  in  1  consumer accepts command.
REQ-015 SHALL have port i_resp_valid  in  1  response word offered.
REQ-016 SHALL have port i_resp_data  in  N_BITS*WORD_BYTES  response word.
REQ-017 SHALL have port o_resp_ready  out  1  controller accepts response.
REQ-018 SHALL have port o_overrun  out  1  sticky: byte dropped while command pending.
REQ-019 SHALL have port o_error  out  1  one-cycle pulse: operand timeout abort.

Function
REQ-020 RX FSM SHALL have states RX_IDLE, RX_OPND, RX_HOLD.
REQ-021 RX_IDLE + i_rx_done: latch byte into o_cmd; if byte[N_BITS-1]=1 -> RX_OPND with byte counter 0, else operand cleared to 0 and -> RX_HOLD.
REQ-022 RX_OPND + i_rx_done: store byte at operand bits [8k+7:8k], k=counter (LSB first); after byte WORD_BYTES-1 -> RX_HOLD.
REQ-023 RX_HOLD SHALL assert o_cmd_valid with o_cmd/o_operand stable; on i_cmd_ready -> RX_IDLE next cycle.
REQ-024 i_rx_done in RX_HOLD SHALL drop the byte and set o_overrun; o_overrun cleared only by reset.
REQ-025 Command-to-valid latency SHALL be 1 cycle after final byte's i_rx_done.
REQ-026 TX FSM SHALL have states TX_IDLE, TX_START, TX_WAIT; o_resp_ready=1 only in TX_IDLE.
REQ-027 TX_IDLE + i_resp_valid: latch i_resp_data, byte index 0 -> TX_START.
REQ-028 TX_START SHALL pulse o_tx_start one cycle with byte index on o_tx_data, -> TX_WAIT.
REQ-029 TX_WAIT + i_tx_done: last byte -> TX_IDLE, else index+1 -> TX_START; bytes sent LSB first.
REQ-030 i_tx_done outside TX_WAIT SHALL be ignored.
REQ-031 RX and TX FSMs SHALL operate independently and concurrently.

Reset
REQ-032 On i_reset low both FSMs SHALL enter idle states immediately; o_tx_start, o_cmd_valid, o_overrun, o_error = 0; o_cmd, o_operand, o_tx_data = 0; o_resp_ready = 1 after release.
REQ-033 Reset mid-transfer SHALL discard partial operand and remaining response bytes.

Configuration
REQ-034 With UART_CTRL_TIMEOUT_EN defined: a cycle counter SHALL reset on each i_rx_done in RX_OPND; reaching TIMEOUT_CYCLES SHALL return RX to RX_IDLE, clear operand, pulse o_error.
REQ-035 Without UART_CTRL_TIMEOUT_EN: no counter; RX_OPND waits indefinitely; o_error tied 0.

Structure
REQ-036 Shared package uart_ctrl_pkg SHALL hold RX/TX state encodings and the operand-flag bit position constant.
REQ-037 TX sequencing SHALL be sub-module uart_ctrl_tx_seq; RX assembly stays in uart_ctrl.

Verification
REQ-038 RX bytes 0x05 -> o_cmd_valid with o_cmd=0x05, o_operand=0x00000000 one cycle later; held until i_cmd_ready.
REQ-039 RX 0x81,0x78,0x56,0x34,0x12 -> o_cmd=0x81, o_operand=0x12345678.
REQ-040 i_resp_data=0xDEADBEEF -> o_tx_data sequence EF,BE,AD,DE, one o_tx_start per i_tx_done; o_resp_ready low throughout.
REQ-041 With command pending and i_cmd_ready=0, RX 0x22 -> o_overrun=1, command unchanged.
REQ-042 (TIMEOUT_EN, TIMEOUT_CYCLES=100) RX 0x81,0x11 then silence 100 cycles -> o_error pulse, RX_IDLE, no o_cmd_valid.
REQ-043 Reset asserted during byte 2 of transmission -> o_tx_start never pulses again, o_resp_ready=1 after release.
